memory_responder: RTL

Data-side memory responder for the pipelined RV32 core: the target end of the core's data-memory port (`memory_address`, `memory_write`, `memory_byte_enable`, `memory_we` in; `memory_read` out). It decodes each access into a byte-enabled word RAM or a small MMIO block: a 64-bit cycle counter and a console byte FIFO drained through a valid/ready output. It sits beside the core in the top-level and simulation harnesses, replacing the bare RAM model.

---
 rtl/cpu_types.sv | 35 +++
 rtl/console_fifo.sv | 61 ++++++
 rtl/memory_responder.sv | 114 +++++++++++
 3 files changed

// File: rtl/cpu_types.sv
// Shared CPU-side definitions: data-memory address map, MMIO offsets and
// STATUS bit positions used by the memory responder.
package cpu_types;

    // MMIO block occupies 16 bytes starting at this address.
    localparam logic [31:0] MMIO_BASE = 32'h8000_0000;

    // MMIO word offsets (memory_address[3:2]).
    localparam logic [1:0] MMIO_CYCLE_LO = 2'd0;
    localparam logic [1:0] MMIO_CYCLE_HI = 2'd1;
    localparam logic [1:0] MMIO_CONSOLE  = 2'd2;
    localparam logic [1:0] MMIO_STATUS   = 2'd3;

    // STATUS register bit positions.
    localparam int STATUS_EMPTY_BIT    = 0;
    localparam int STATUS_FULL_BIT     = 1;
    localparam int STATUS_OVERFLOW_BIT = 2;

    typedef enum logic [1:0] {
        REGION_RAM,
        REGION_MMIO,
        REGION_UNMAPPED
    } region_e;

    // Classify a byte address; bits [1:0] never take part in decode.
    function automatic region_e decode_region(input logic [31:0] addr);
        if (!addr[31])
            return REGION_RAM;
        else if (addr[31:4] == MMIO_BASE[31:4])
            return REGION_MMIO;
        else
            return REGION_UNMAPPED;
    endfunction

endpackage

// File: rtl/console_fifo.sv
// Small synchronous FIFO for console bytes. Push while full is accepted only
// when a pop happens in the same cycle; push and pop on empty stores the push.
module console_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    output logic                     full,
    input  logic                     pop,
    output logic                     empty,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_BITS = $clog2(DEPTH);
    localparam logic [PTR_BITS:0] DEPTH_COUNT = (PTR_BITS + 1)'(DEPTH);

    logic [WIDTH-1:0]    mem [DEPTH];
    logic [PTR_BITS-1:0] wr_ptr;
    logic [PTR_BITS-1:0] rd_ptr;
    logic                do_push;
    logic                do_pop;

    assign empty   = (count == '0);
    assign full    = (count == DEPTH_COUNT);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    // Head reads as zero while empty so reset and drained states look identical.
    assign head    = empty ? '0 : mem[rd_ptr];

    // Storage write; data needs no reset because empty masks the head.
    // NOTE: arrays are left out of the reset so they map onto plain RAM cells.
    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= push_data;
    end

    // Pointer and occupancy bookkeeping.
    // NOTE: state registers use <= so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/memory_responder.sv
// Data-side memory responder: decodes core accesses into a byte-enabled word
// RAM or an MMIO block (64-bit cycle counter, console FIFO, STATUS).
module memory_responder
    import cpu_types::*;
#(
    parameter int RAM_ADDR_BITS = 10,
    parameter int FIFO_DEPTH    = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] memory_address,
    input  logic [31:0] memory_write,
    input  logic [3:0]  memory_byte_enable,
    input  logic        memory_we,
    output logic [31:0] memory_read,
    output logic [7:0]  console_data,
    output logic        console_valid,
    input  logic        console_ready
);

    logic [31:0]              ram [2**RAM_ADDR_BITS];
    logic [RAM_ADDR_BITS-1:0] ram_index;
    region_e                  region;
    logic [1:0]               mmio_offset;
    logic                     mmio_we;
    logic                     ram_we;
    logic [63:0]              cycle_count;
    logic                     overflow;
    logic                     console_push;
    logic                     console_pop;
    logic                     status_clear;
    logic                     fifo_full;
    logic                     fifo_empty;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;
    logic                     unused_ok;

    assign region       = decode_region(memory_address);
    assign ram_index    = memory_address[RAM_ADDR_BITS+1:2];
    assign mmio_offset  = memory_address[3:2];
    assign ram_we       = memory_we && (region == REGION_RAM);
    assign mmio_we      = memory_we && (region == REGION_MMIO);
    assign console_push = mmio_we && (mmio_offset == MMIO_CONSOLE) && memory_byte_enable[0];
    assign status_clear = mmio_we && (mmio_offset == MMIO_STATUS) && memory_byte_enable[0]
                          && memory_write[STATUS_OVERFLOW_BIT];
    assign console_pop  = console_valid && console_ready;
    assign console_valid = !fifo_empty;
    assign unused_ok    = &{1'b0, memory_address[1:0], fifo_count};

    console_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_console_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (console_push),
        .push_data (memory_write[7:0]),
        .full      (fifo_full),
        .pop       (console_pop),
        .empty     (fifo_empty),
        .head      (console_data),
        .count     (fifo_count)
    );

    // RAM lane writes; a write coinciding with an asserted rst is dropped.
    always_ff @(posedge clk) begin
        if (!rst && ram_we) begin
            for (int lane = 0; lane < 4; lane++) begin
                if (memory_byte_enable[lane])
                    ram[ram_index][8*lane +: 8] <= memory_write[8*lane +: 8];
            end
        end
    end

    // Free-running 64-bit cycle counter, wraps naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cycle_count <= '0;
        else
            cycle_count <= cycle_count + 64'd1;
    end

    // Sticky overflow: a dropped console push sets it and beats a same-cycle clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            overflow <= 1'b0;
        else if (console_push && fifo_full && !console_pop)
            overflow <= 1'b1;
        else if (status_clear)
            overflow <= 1'b0;
    end

    // Combinational read mux; the core needs data in the same cycle.
    // NOTE: default assigned first so no path leaves memory_read holding a latch.
    always_comb begin
        memory_read = '0;
        case (region)
            REGION_RAM: memory_read = ram[ram_index];
            REGION_MMIO: begin
                case (mmio_offset)
                    MMIO_CYCLE_LO: memory_read = cycle_count[31:0];
                    MMIO_CYCLE_HI: memory_read = cycle_count[63:32];
                    MMIO_STATUS: begin
                        memory_read[STATUS_EMPTY_BIT]    = fifo_empty;
                        memory_read[STATUS_FULL_BIT]     = fifo_full;
                        memory_read[STATUS_OVERFLOW_BIT] = overflow;
                    end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

endmodule
